// File: rtl/rand_arbiter.sv
// rtl/rand_arbiter.sv - round-robin arbiter serving LFSR values reduced to 1..RANGE
// Optional feature macro: RAND_NOREPEAT_EN (suppresses back-to-back identical results)
module rand_arbiter #(
  parameter int          NREQ  = 4,
  parameter int          RANGE = 9,
  parameter logic [7:0]  SEED  = 8'hA5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            seed_load,
  input  logic [7:0]      seed_val,
  output logic [NREQ-1:0] gnt,
  output logic [3:0]      rnd_data,
  output logic            rnd_valid,
  output logic            busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, REDUCE} state_t;

  state_t          state;
  logic [7:0]      lfsr;
  logic [7:0]      cap;
  logic [3:0]      rem;
  logic [2:0]      k;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win_q;

  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic [4:0]      p;
  logic [3:0]      rem_step;
  logic [3:0]      result;

`ifdef RAND_NOREPEAT_EN
  logic [3:0]      last_val;
`endif

  // Free-running LFSR; a seed load replaces the advance, zero seed maps to SEED
  always_ff @(posedge clk) begin
    if (rst)
      lfsr <= SEED;
    else if (seed_load)
      lfsr <= (seed_val == 8'd0) ? SEED : seed_val;
    else
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Round-robin search starting at ptr, wrapping modulo NREQ
  always_comb begin
    int j;
    win_found = 1'b0;
    win_idx   = ptr;
    j         = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ)
        j = j - NREQ;
      if (!win_found && req[j]) begin
        win_found = 1'b1;
        win_idx   = IW'(j);
      end
    end
  end

  // One shift-subtract modulo step, plus the delivered value for the final step
  always_comb begin
    p        = {rem, cap[k]};
    rem_step = (p >= 5'(RANGE)) ? 4'(p - 5'(RANGE)) : p[3:0];
    result   = rem_step + 4'd1;
`ifdef RAND_NOREPEAT_EN
    if (result == last_val)
      result = (result == 4'(RANGE)) ? 4'd1 : result + 4'd1;
`endif
  end

  // Control FSM: arbitrate, capture the LFSR, reduce over 8 cycles, deliver
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cap       <= '0;
      rem       <= '0;
      k         <= '0;
      ptr       <= '0;
      win_q     <= '0;
      gnt       <= '0;
      rnd_data  <= '0;
      rnd_valid <= 1'b0;
`ifdef RAND_NOREPEAT_EN
      last_val  <= '0;
`endif
    end else begin
      rnd_valid <= 1'b0;
      gnt       <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            win_q <= win_idx;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          cap   <= lfsr;
          rem   <= '0;
          k     <= 3'd7;
          state <= REDUCE;
        end
        REDUCE: begin
          rem <= rem_step;
          if (k == 3'd0) begin
            rnd_data  <= result;
            rnd_valid <= 1'b1;
            gnt       <= NREQ'(1) << win_q;
            ptr       <= (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
`ifdef RAND_NOREPEAT_EN
            last_val  <= result;
`endif
            state     <= IDLE;
          end else begin
            k <= k - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rand_arbiter.sv
// tb/tb_rand_arbiter.sv - directed self-checking bench for rand_arbiter
module tb_rand_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       seed_load;
  logic [7:0] seed_val;
  logic [3:0] gnt;
  logic [3:0] rnd_data;
  logic       rnd_valid;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  rand_arbiter #(.NREQ(4), .RANGE(9), .SEED(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .seed_load (seed_load),
    .seed_val  (seed_val),
    .gnt       (gnt),
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request with optional seed load at E0; a stray seed load mid-reduce must not matter
  task automatic run_op(input logic [3:0] mask, input logic ld, input logic [7:0] sv,
                        input logic [3:0] egnt, input logic [3:0] edata);
    int n;
    @(negedge clk);
    req = mask; seed_load = ld; seed_val = sv;
    @(negedge clk);
    seed_load = 1'b0;
    n = 1;
    check("busy_after_e0", {31'd0, busy}, 32'd1);
    while (!rnd_valid && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 4) begin seed_load = 1'b1; seed_val = 8'h33; end
      else seed_load = 1'b0;
    end
    req = '0;
    seed_load = 1'b0;
    check("latency", n, 32'd10);
    check("gnt", {28'd0, gnt}, {28'd0, egnt});
    check("rnd_data", {28'd0, rnd_data}, {28'd0, edata});
    check("busy_at_valid", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("valid_pulse_end", {27'd0, rnd_valid, gnt}, 32'd0);
    check("rnd_data_hold", {28'd0, rnd_data}, {28'd0, edata});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] gseq [5];
    int         gcyc [5];
    int         ng;
    logic [3:0] exp_g [5];
    int         n;
    int         extra;

    rst = 1'b1; req = '0; seed_load = 1'b0; seed_val = '0;

    // Reset state and LFSR sequence from the seed
    repeat (3) @(negedge clk);
    check("lfsr_reset", {24'd0, dut.lfsr}, 32'h00A5);
    rst = 1'b0;
    @(negedge clk);
    check("lfsr_1", {24'd0, dut.lfsr}, 32'h004A);
    @(negedge clk);
    check("lfsr_2", {24'd0, dut.lfsr}, 32'h0095);
    @(negedge clk);
    check("lfsr_3", {24'd0, dut.lfsr}, 32'h002A);
    for (int c = 0; c < 20; c++) begin
      check("idle_outputs", {23'd0, rnd_valid, gnt, busy, rnd_data}, 32'd0);
      @(negedge clk);
    end

    // Seeded results: (seed mod 9) + 1
    run_op(4'b0001, 1'b1, 8'd100, 4'b0001, 4'd2);
    run_op(4'b0001, 1'b1, 8'd255, 4'b0001, 4'd4);
    run_op(4'b0001, 1'b1, 8'd9,   4'b0001, 4'd1);
    run_op(4'b0001, 1'b1, 8'd0,   4'b0001, 4'd4);

    // Same seed twice in a row
    run_op(4'b0001, 1'b1, 8'd100, 4'b0001, 4'd2);
`ifdef RAND_NOREPEAT_EN
    run_op(4'b0001, 1'b1, 8'd100, 4'b0001, 4'd3);
`else
    run_op(4'b0001, 1'b1, 8'd100, 4'b0001, 4'd2);
`endif

    // Round-robin under continuous request from reset
    @(negedge clk);
    rst = 1'b1; req = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    ng = 0;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    for (int c = 0; c < 80 && ng < 5; c++) begin
      @(negedge clk);
      if (gnt != 4'b0000) begin
        gseq[ng] = gnt;
        gcyc[ng] = c;
        ng++;
      end
    end
    req = '0;
    check("rr_count", ng, 32'd5);
    for (int i = 0; i < ng; i++) begin
      check("rr_gnt", {28'd0, gseq[i]}, {28'd0, exp_g[i]});
      if (i > 0) check("rr_spacing", gcyc[i] - gcyc[i-1], 32'd10);
    end

    // Requester drops req at E2; grant still delivered, then nothing more
    @(negedge clk);
    req = 4'b0100;
    n = 0;
    @(negedge clk); n = 1;
    @(negedge clk); n = 2;
    req = '0;
    while (!rnd_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drop_latency", n, 32'd10);
    check("drop_gnt", {28'd0, gnt}, 32'h4);
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt != 4'b0000 || rnd_valid) extra++;
    end
    check("drop_no_more", extra, 32'd0);

    // Reset at E5 of an operation discards it
    @(negedge clk);
    req = 4'b0010;
    for (int i = 1; i <= 5; i++) @(negedge clk);
    rst = 1'b1; req = '0;
    @(negedge clk);
    check("rst_outputs", {23'd0, rnd_valid, gnt, busy, rnd_data}, 32'd0);
    check("rst_lfsr", {24'd0, dut.lfsr}, 32'h00A5);
    rst = 1'b0;
    extra = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (rnd_valid || busy) extra++;
    end
    check("rst_no_valid", extra, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
